clock_divider_prog: RTL and testbench
=====================================

// Module: clock_divider_prog
// PURPOSE
//   Multi-channel programmable clock divider. Each channel divides clk by a
//   runtime divisor N with a programmable high time H. Channels start and stop
//   glitch-free. Divisor changes take effect only at period boundaries.
//   Generalises the fixed single divider; feeds per-peripheral clock/strobe nets.
// PARAMETERS
//   NUM_CH       2   number of independent divider channels (>=1)
//   DIV_W        8   width of divisor / high-time fields (>=2)
//   DEFAULT_DIV  2   divisor loaded at reset (2..2**DIV_W-1); reset H = DEFAULT_DIV/2
// PORTS
//   clk        in   1       single system clock
//   reset      in   1       synchronous, active-high reset
//   en         in   NUM_CH  per-channel run request
//   div_valid  in   1       config request valid
//   div_ready  out  1       config request can be accepted
//   div_ch     in   CH_W    target channel; CH_W = max(1,$clog2(NUM_CH))
//   div_value  in   DIV_W   new divisor N
//   div_high   in   DIV_W   new high time H in clk cycles (0 = floor(N/2))
//   clk_out    out  NUM_CH  divided outputs, registered
//   tick       out  NUM_CH  1-cycle pulse on the cycle clk_out[i] rises
//   cfg_err    out  1       sticky: illegal request seen
// BEHAVIOUR
// - Reset (sync, highest priority, wins over all inputs): every channel IDLE,
//   cnt=0, N=DEFAULT_DIV, H=DEFAULT_DIV/2, no pending; clk_out=0, tick=0,
//   cfg_err=0, div_ready=1. Reset mid-period truncates the output at once.
// - Per-channel FSM, states IDLE/RUN; next = (cnt==N-1) ? 0 : cnt+1.
//   IDLE: cnt=0, clk_out=0, tick=0. If en[i]=1: next edge cnt<=0,
//     clk_out<=1, tick<=1, go RUN (1-cycle latency from en to first rise).
//   RUN, next!=0: cnt<=next, clk_out<=(next<H), tick<=0; en ignored.
//   RUN, next==0 (period boundary): apply pending config first, then
//     if en[i]=1: cnt<=0, clk_out<=1, tick<=1, stay RUN;
//     else: clk_out<=0, tick<=0, go IDLE. en drop never truncates a period.
// - Result: period N cycles, clk_out high H cycles, low N-H cycles.
// - Config handshake: transfer when div_valid && div_ready.
//   div_ready = !pending[div_ch] (combinational from div_ch).
//   Legal request (2<=div_value, div_ch<NUM_CH): H_eff = (div_high==0) ?
//     div_value>>1 : min(div_high, div_value-1). Stored as pending for channel.
//     Target IDLE: applied on the accepting edge (pending not set).
//     Target RUN: applied at the next period boundary; pending cleared then.
//   Illegal request (div_value<2 or div_ch>=NUM_CH): accepted, discarded,
//     cfg_err<=1 (sticky until reset); no channel state changes.
// - Pending request and boundary on the same edge: boundary applies the old
//   pending; the new request becomes pending (ready was low, so it cannot occur).
// - Channels fully independent; one config port serves all.
// - cnt is DIV_W bits; max divisor 2**DIV_W-1; no wrap beyond N-1.
// TESTING
//   1 reset, en[0]=1 -> clk_out[0] 1,0,1,0 from cycle 1; tick[0] every 2nd cycle.
//   2 in RUN, write ch0 N=5 H=0 mid-period -> current period completes, then
//     high 2 / low 3 repeating; div_ready low for ch0 until boundary.
//   3 write ch1 N=6 H=9 while IDLE, en[1]=1 -> high 5 / low 1; div_ready stays 1.
//   4 write div_value=1 -> cfg_err=1, ch0 period unchanged; remains 1 after.
//   5 ch0 N=4 H=2 running, drop en at cnt=1 -> 2 more cycles then clk_out=0,
//     IDLE; re-raise en -> rise 1 cycle later, full period, no runt.
//   6 reset asserted mid-high with both channels running -> next edge all
//     clk_out=0, tick=0, N back to DEFAULT_DIV, cfg_err=0.

Source files
------------

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: per-channel runtime divisor and high time,
// glitch-free start/stop, configuration changes land only on period boundaries.
module clock_divider_prog #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_value,
    input  logic [DIV_W-1:0]  div_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_err
);

    localparam logic [DIV_W-1:0] ZERO_W   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_W    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] TWO_W    = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_N    = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DEF_H    = DIV_W'(DEFAULT_DIV / 2);
    localparam logic [CH_W:0]    NUM_CH_C = (CH_W + 1)'(NUM_CH);

    // High time actually used: 0 means half the period, otherwise clamped below N.
    function automatic logic [DIV_W-1:0] high_eff(input logic [DIV_W-1:0] n,
                                                  input logic [DIV_W-1:0] h);
        logic [DIV_W-1:0] r;
        if (h == ZERO_W) begin
            r = n >> 1;
        end else if (h > (n - ONE_W)) begin
            r = n - ONE_W;
        end else begin
            r = h;
        end
        return r;
    endfunction

    logic [NUM_CH-1:0]            run_q, run_d;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d, n_q, n_d, h_q, h_d, pn_q, pn_d, ph_q, ph_d;
    logic [NUM_CH-1:0]            pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;
    logic                         cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0][DIV_W-1:0] nxt_s;
    logic [NUM_CH-1:0]            bnd_s;
    logic                         acc_s, legal_s;
    logic [DIV_W-1:0]             heff_s;

    // State register: sync reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q     <= {NUM_CH{1'b0}};
            cnt_q     <= {NUM_CH{ZERO_W}};
            n_q       <= {NUM_CH{DEF_N}};
            h_q       <= {NUM_CH{DEF_H}};
            pn_q      <= {NUM_CH{DEF_N}};
            ph_q      <= {NUM_CH{DEF_H}};
            pend_q    <= {NUM_CH{1'b0}};
            clk_out_q <= {NUM_CH{1'b0}};
            tick_q    <= {NUM_CH{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            h_q       <= h_d;
            pn_q      <= pn_d;
            ph_q      <= ph_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Per-channel position in the period and boundary detection.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bnd_s[i] = run_q[i] && (cnt_q[i] == (n_q[i] - ONE_W));
            nxt_s[i] = (cnt_q[i] == (n_q[i] - ONE_W)) ? ZERO_W : (cnt_q[i] + ONE_W);
        end
    end

    // Config handshake: a channel with a pending request blocks further writes to it.
    always_comb begin
        div_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (div_ch == CH_W'(i)) begin
                div_ready = !pend_q[i];
            end else begin
                div_ready = div_ready;
            end
        end
        acc_s   = div_valid && div_ready;
        legal_s = (div_value >= TWO_W) && ({1'b0, div_ch} < NUM_CH_C);
        heff_s  = high_eff(div_value, div_high);
    end

    // Next-state: counters, divisor registers and the pending config slot.
    always_comb begin
        run_d     = run_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        h_d       = h_q;
        pn_d      = pn_q;
        ph_d      = ph_q;
        pend_d    = pend_q;
        cfg_err_d = cfg_err_q | (acc_s && !legal_s);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!run_q[i]) begin
                cnt_d[i] = ZERO_W;
                run_d[i] = en[i];
            end else if (!bnd_s[i]) begin
                cnt_d[i] = nxt_s[i];
            end else begin
                cnt_d[i] = ZERO_W;
                run_d[i] = en[i];
                if (pend_q[i]) begin
                    n_d[i]    = pn_q[i];
                    h_d[i]    = ph_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = 1'b0;
                end
            end
            // Accepted request implies pend_q[i]==0, so it never collides with a boundary apply.
            if (acc_s && legal_s && (div_ch == CH_W'(i))) begin
                if (run_q[i]) begin
                    pend_d[i] = 1'b1;
                    pn_d[i]   = div_value;
                    ph_d[i]   = heff_s;
                end else begin
                    n_d[i] = div_value;
                    h_d[i] = heff_s;
                end
            end else begin
                pend_d[i] = pend_d[i];
            end
        end
    end

    // Output decode: values registered on the next edge.
    always_comb begin
        clk_out_d = {NUM_CH{1'b0}};
        tick_d    = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (!run_q[i] || bnd_s[i]) begin
                clk_out_d[i] = en[i];
                tick_d[i]    = en[i];
            end else begin
                clk_out_d[i] = (nxt_s[i] < h_q[i]);
                tick_d[i]    = 1'b0;
            end
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed scenarios plus randomized
// traffic against a period-timeline reference model.
module tb_clock_divider_prog;

    localparam int NUM_CH = 2;
    localparam int DEF    = 2;

    logic       clk;
    logic       reset;
    logic [1:0] en;
    logic       div_valid;
    logic       div_ready;
    logic [0:0] div_ch;
    logic [7:0] div_value;
    logic [7:0] div_high;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    // Model: each channel is a timeline of periods; a period starts at cycle m_start.
    int cyc = 0;
    bit m_act[NUM_CH];
    int m_start[NUM_CH];
    int m_per[NUM_CH];
    int m_hi[NUM_CH];
    bit m_pend[NUM_CH];
    int m_pper[NUM_CH];
    int m_phi[NUM_CH];
    bit m_out[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_err = 1'b0;

    clock_divider_prog #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .en(en), .div_valid(div_valid), .div_ready(div_ready),
        .div_ch(div_ch), .div_value(div_value), .div_high(div_high),
        .clk_out(clk_out), .tick(tick), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int eff_high(input int n, input int h);
        if (h == 0) return n / 2;
        return (h < n - 1) ? h : n - 1;
    endfunction

    task automatic model_edge();
        bit pre_act[NUM_CH];
        bit pre_pend[NUM_CH];
        int age;
        int ch;
        cyc++;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_act[c] = 0; m_per[c] = DEF; m_hi[c] = DEF / 2; m_pend[c] = 0;
                m_out[c] = 0; m_tick[c] = 0;
            end
            m_err = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pre_act[c]  = m_act[c];
                pre_pend[c] = m_pend[c];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                age = cyc - m_start[c];
                if (!m_act[c] || age == m_per[c]) begin
                    if (m_act[c] && m_pend[c]) begin
                        m_per[c] = m_pper[c]; m_hi[c] = m_phi[c]; m_pend[c] = 0;
                    end
                    m_act[c] = en[c]; m_start[c] = cyc;
                    m_out[c] = en[c]; m_tick[c] = en[c];
                end else begin
                    m_out[c] = (age < m_hi[c]); m_tick[c] = 0;
                end
            end
            ch = int'(div_ch);
            if (div_valid && !pre_pend[ch]) begin
                if (div_value < 2) begin
                    m_err = 1;
                end else if (pre_act[ch]) begin
                    m_pend[ch] = 1; m_pper[ch] = int'(div_value);
                    m_phi[ch] = eff_high(int'(div_value), int'(div_high));
                end else begin
                    m_per[ch] = int'(div_value);
                    m_hi[ch] = eff_high(int'(div_value), int'(div_high));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 2'b00; div_valid = 1'b0; div_ch = 1'b0;
        div_value = 8'd0; div_high = 8'd0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out got %b exp 00", clk_out); end
        checks++; if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick got %b exp 00", tick); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", div_ready); end
    endtask

    task automatic test_basic();
        en = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (clk_out[0] !== ((k % 2) == 0)) begin
                errors++; $display("FAIL basic_clk k=%0d got %b exp %b", k, clk_out[0], (k % 2) == 0);
            end
            checks++;
            if (tick[0] !== ((k % 2) == 0)) begin
                errors++; $display("FAIL basic_tick k=%0d got %b exp %b", k, tick[0], (k % 2) == 0);
            end
        end
    endtask

    task automatic test_mid_change();
        int guard = 0;
        while (!m_out[0] && guard < 10) begin step(); guard++; end
        div_valid = 1'b1; div_ch = 1'b0; div_value = 8'd5; div_high = 8'd0;
        #1;
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_pre got %b exp 1", div_ready); end
        step();
        div_valid = 1'b0;
        #1;
        checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pend got %b exp 0", div_ready); end
        checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL mid_old_low got %b exp 0", clk_out[0]); end
        step();
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_post got %b exp 1", div_ready); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (clk_out[0] !== ((k % 5) < 2)) begin
                errors++; $display("FAIL mid_n5_clk k=%0d got %b exp %b", k, clk_out[0], (k % 5) < 2);
            end
            checks++;
            if (tick[0] !== ((k % 5) == 0)) begin
                errors++; $display("FAIL mid_n5_tick k=%0d got %b exp %b", k, tick[0], (k % 5) == 0);
            end
            step();
        end
    endtask

    task automatic test_idle_cfg();
        div_valid = 1'b1; div_ch = 1'b1; div_value = 8'd6; div_high = 8'd9;
        #1;
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_pre got %b exp 1", div_ready); end
        step();
        div_valid = 1'b0;
        #1;
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_post got %b exp 1", div_ready); end
        en[1] = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (clk_out[1] !== ((k % 6) < 5)) begin
                errors++; $display("FAIL idle_n6_clk k=%0d got %b exp %b", k, clk_out[1], (k % 6) < 5);
            end
            checks++;
            if (tick[1] !== ((k % 6) == 0)) begin
                errors++; $display("FAIL idle_n6_tick k=%0d got %b exp %b", k, tick[1], (k % 6) == 0);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        int ticks = 0;
        div_valid = 1'b1; div_ch = 1'b0; div_value = 8'd1; div_high = 8'd0;
        step();
        div_value = 8'd0;
        step();
        div_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", cfg_err); end
        for (int k = 0; k < 10; k++) begin
            step();
            ticks += int'(tick[0]);
            checks++;
            if (clk_out[0] !== m_out[0]) begin
                errors++; $display("FAIL illegal_ch0_clk k=%0d got %b exp %b", k, clk_out[0], m_out[0]);
            end
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL illegal_period ticks got %0d exp 2", ticks); end
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b exp 1", cfg_err); end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        div_valid = 1'b1; div_ch = 1'b0; div_value = 8'd4; div_high = 8'd2;
        step();
        div_valid = 1'b0;
        while (!m_tick[0] && guard < 20) begin step(); guard++; end
        checks++; if (guard >= 20) begin errors++; $display("FAIL drop_wait_tick got timeout exp tick"); end
        step();
        checks++; if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL drop_cnt1 got %b exp 1", clk_out[0]); end
        en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
                errors++; $display("FAIL drop_low k=%0d got clk %b tick %b exp 0 0", k, clk_out[0], tick[0]);
            end
        end
        en[0] = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 0)) begin
                errors++; $display("FAIL drop_restart k=%0d got clk %b tick %b exp %b %b",
                                   k, clk_out[0], tick[0], (k % 4) < 2, (k % 4) == 0);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        en = 2'b11;
        while (!(m_out[0] && m_out[1]) && guard < 30) begin step(); guard++; end
        checks++; if (guard >= 30) begin errors++; $display("FAIL rst_mid_wait got timeout exp both high"); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL rst_mid_clk got %b exp 00", clk_out); end
        checks++; if (tick !== 2'b00) begin errors++; $display("FAIL rst_mid_tick got %b exp 00", tick); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b exp 0", cfg_err); end
        checks++; if (div_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", div_ready); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (clk_out !== (((k % 2) == 0) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL rst_mid_default k=%0d got %b exp %b", k, clk_out, ((k % 2) == 0) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 11) == 0) en = 2'($urandom);
            div_valid = ($urandom_range(0, 3) == 0);
            div_ch    = 1'($urandom);
            div_value = 8'($urandom_range(0, 12));
            div_high  = 8'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 249) == 0);
            #1;
            exp_rdy = !m_pend[int'(div_ch)];
            checks++;
            if (div_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, div_ready, exp_rdy);
            end
            step();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                checks++;
                if (clk_out[ch] !== m_out[ch] || tick[ch] !== m_tick[ch]) begin
                    errors++; $display("FAIL rand_out c=%0d ch=%0d got clk %b tick %b exp %b %b",
                                       c, ch, clk_out[ch], tick[ch], m_out[ch], m_tick[ch]);
                end
            end
            checks++;
            if (cfg_err !== m_err) begin
                errors++; $display("FAIL rand_err c=%0d got %b exp %b", c, cfg_err, m_err);
            end
        end
        reset = 1'b0; div_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_change();
        test_idle_cfg();
        test_illegal();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
